// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - register map, control/status bit indices and bus width for echo capture
package sonar_pkg;

  localparam int BUS_WIDTH = 16;

  typedef logic [BUS_WIDTH-1:0] bus_word_t;

  localparam logic [3:0] ADR_STATUS   = 4'd0;
  localparam logic [3:0] ADR_HEAD_HI  = 4'd1;
  localparam logic [3:0] ADR_HEAD_LO  = 4'd2;
  localparam logic [3:0] ADR_CTRL     = 4'd3;
  localparam logic [3:0] ADR_ARMED    = 4'd4;
  localparam logic [3:0] ADR_TIMER_LO = 4'd5;
  localparam logic [3:0] ADR_TIMER_HI = 4'd6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CLR_OVF = 2;
  localparam int CTRL_FLUSH   = 3;

  localparam int ST_EMPTY  = 6;
  localparam int ST_FULL   = 7;
  localparam int ST_OVF    = 8;
  localparam int ST_TS_SAT = 9;

endpackage

// File: rtl/echo_capture_if.sv
// rtl/echo_capture_if.sv - CPU register bus between firmware master and the echo capture slave
interface echo_capture_if;
  import sonar_pkg::*;

  logic      wb_valid_i;
  logic [3:0] wbs_adr_i;
  bus_word_t wbs_dat_i;
  logic      wbs_strb_i;
  logic      wbs_ack_o;
  bus_word_t wbs_dat_o;

  modport master (
    output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - timestamp FIFO; a pop in the same cycle frees room for a push when full
module capture_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/echo_capture.sv
// rtl/echo_capture.sv - timestamps the first echo per channel after a ping and queues it for the CPU
module echo_capture
  import sonar_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int TS_W   = 24,
  parameter int DEPTH  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  echo_capture_if.slave     bus,
  input  logic [NUM_CH-1:0] cmp_i,
  input  logic              ce_pcm,
  input  logic              mclear,
  output logic              irq_o
);

  localparam int EW = 4 + TS_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TS_W-1:0] TS_MAX = '1;

  logic [TS_W-1:0]   timer_q, timer_d;
  logic              ts_sat_q, ts_sat_d, ovf_q, ovf_d;
  logic [NUM_CH-1:0] armed_q, armed_d, pending_q, pending_d, cmp_q;
  logic [NUM_CH-1:0] rise, cap, grant;
  logic [TS_W-1:0]   ts_hold_q [NUM_CH];
  logic              en_q, irq_en_q, clr_q, flush_q, valid_q, ack_q;
  bus_word_t         rdata_q, rdata_d, reg_mux;
  logic              start, rd_en, wr_en, ctrl_wr, pop_req, push_req, fifo_push;
  logic [3:0]        push_ch;
  logic [TS_W-1:0]   push_ts;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic [EW-1:0]     head;
  logic              unused_wdata;

  // Only the first cycle of a held valid is acted on.
  assign start   = bus.wb_valid_i & ~valid_q;
  assign rd_en   = start & ~bus.wbs_strb_i;
  assign wr_en   = start & bus.wbs_strb_i;
  assign ctrl_wr = wr_en & (bus.wbs_adr_i == ADR_CTRL);
  assign pop_req = rd_en & (bus.wbs_adr_i == ADR_HEAD_LO);
  assign unused_wdata = ^bus.wbs_dat_i[BUS_WIDTH-1:4];

  assign rise = cmp_i & ~cmp_q;
  assign cap  = mclear ? '0 : (rise & armed_q & {NUM_CH{en_q}});

  // Downward scan so the lowest pending channel wins.
  always_comb begin
    push_req = 1'b0;
    push_ch  = '0;
    push_ts  = '0;
    grant    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_req = 1'b1;
        push_ch  = 4'(i);
        push_ts  = ts_hold_q[i];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign fifo_push = push_req & ~flush_q;

  capture_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n),
    .push_i  (fifo_push),
    .data_i  ({push_ch, push_ts}),
    .pop_i   (pop_req),
    .flush_i (flush_q),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  always_comb begin
    timer_d = timer_q;
    if (mclear)                                        timer_d = '0;
    else if (en_q && ce_pcm && (timer_q != TS_MAX))    timer_d = timer_q + TS_W'(1);
    ts_sat_d  = ~clr_q & (ts_sat_q | (timer_q == TS_MAX));
    ovf_d     = ~clr_q & (ovf_q | (fifo_push & full & ~(pop_req & ~empty)));
    armed_d   = mclear ? '1 : (armed_q & ~cap);
    pending_d = (mclear || flush_q) ? cap : ((pending_q & ~grant) | cap);
  end

  always_comb begin
    reg_mux = '0;
    case (bus.wbs_adr_i)
      ADR_STATUS: begin
        reg_mux[5:0]      = 6'(count);
        reg_mux[ST_EMPTY] = empty;
        reg_mux[ST_FULL]  = full;
        reg_mux[ST_OVF]   = ovf_q;
        reg_mux[ST_TS_SAT] = ts_sat_q;
      end
      ADR_HEAD_HI:  if (!empty) reg_mux = {head[EW-1 -: 4], 12'(head[TS_W-1:16])};
      ADR_HEAD_LO:  if (!empty) reg_mux = head[15:0];
      ADR_CTRL: begin
        reg_mux[CTRL_EN]     = en_q;
        reg_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      ADR_ARMED:    reg_mux = BUS_WIDTH'(armed_q);
      ADR_TIMER_LO: reg_mux = timer_q[15:0];
      ADR_TIMER_HI: reg_mux = BUS_WIDTH'(timer_q[TS_W-1:16]);
      default:      reg_mux = '0;
    endcase
    rdata_d = rd_en ? reg_mux : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      timer_q   <= '0;
      ts_sat_q  <= 1'b0;
      ovf_q     <= 1'b0;
      armed_q   <= '0;
      pending_q <= '0;
      cmp_q     <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      clr_q     <= 1'b0;
      flush_q   <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) ts_hold_q[i] <= '0;
    end else begin
      timer_q   <= timer_d;
      ts_sat_q  <= ts_sat_d;
      ovf_q     <= ovf_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
      cmp_q     <= cmp_i;
      valid_q   <= bus.wb_valid_i;
      ack_q     <= start;
      rdata_q   <= rdata_d;
      clr_q     <= ctrl_wr & bus.wbs_dat_i[CTRL_CLR_OVF];
      flush_q   <= ctrl_wr & bus.wbs_dat_i[CTRL_FLUSH];
      if (ctrl_wr) begin
        en_q     <= bus.wbs_dat_i[CTRL_EN];
        irq_en_q <= bus.wbs_dat_i[CTRL_IRQ_EN];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) ts_hold_q[i] <= timer_q;
      end
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdata_q;
  assign irq_o         = irq_en_q & ~empty;

endmodule

// File: tb/tb_echo_capture.sv
// tb/tb_echo_capture.sv - randomized scoreboard bench for echo_capture against a queue-based model
module tb_echo_capture;

  localparam int NUM_CH = 6;
  localparam int TS_W   = 24;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] cmp = '0;
  logic              ce = 1'b0;
  logic              mclr = 1'b0;
  logic              irq;

  echo_capture_if bus_if ();

  echo_capture #(.NUM_CH(NUM_CH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus_if.slave),
    .cmp_i    (cmp),
    .ce_pcm   (ce),
    .mclear   (mclr),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  adr;
    logic [15:0] data;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t mon_x;

  // Reference model: captured echoes as (ch << 24) | ticks-since-ping.
  int          m_fifo[$];
  bit [NUM_CH-1:0] m_armed;
  int          m_ticks;
  bit          m_ovf, m_en, m_irq_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] adr);
    int e, r;
    r = 0;
    case (adr)
      4'd0: begin
        r = m_fifo.size();
        if (m_fifo.size() == 0)     r += 64;
        if (m_fifo.size() == DEPTH) r += 128;
        if (m_ovf)                  r += 256;
      end
      4'd1: if (m_fifo.size() != 0) begin
        e = m_fifo[0];
        r = ((e >> 24) << 12) | ((e & 32'hFFFFFF) >> 16);
      end
      4'd2: if (m_fifo.size() != 0) begin
        e = m_fifo.pop_front();
        r = e & 32'hFFFF;
      end
      4'd3: r = int'(m_en) + 2 * int'(m_irq_en);
      4'd4: r = int'(m_armed);
      4'd5: r = m_ticks & 32'hFFFF;
      4'd6: r = m_ticks >> 16;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic model_write(input logic [3:0] adr, input logic [15:0] d);
    if (adr == 4'd3) begin
      m_en     = d[0];
      m_irq_en = d[1];
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_fifo.delete();
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_acc(input bit wr, input logic [3:0] adr, input logic [15:0] d, input int hold);
    exp_t x;
    x.adr = adr;
    if (wr) begin
      model_write(adr, d);
      x.data = 16'h0;
    end else begin
      x.data = model_read(adr);
    end
    exp_q.push_back(x);
    bus_if.wb_valid_i = 1'b1;
    bus_if.wbs_adr_i  = adr;
    bus_if.wbs_dat_i  = d;
    bus_if.wbs_strb_i = wr;
    cyc(hold);
    bus_if.wb_valid_i = 1'b0;
    bus_if.wbs_strb_i = 1'b0;
    cyc(1);
    check($sformatf("ack_seen_adr%0d", adr), exp_q.size(), 0);
  endtask

  task automatic rd(input logic [3:0] adr);
    bus_acc(1'b0, adr, 16'h0, 1);
  endtask

  task automatic wr_ctrl(input logic [15:0] d);
    bus_acc(1'b1, 4'd3, d, 1);
  endtask

  task automatic ping();
    mclr = 1'b1;
    cyc(1);
    mclr = 1'b0;
    m_ticks = 0;
    m_armed = '1;
  endtask

  task automatic ticks(input int n);
    if (n > 0) begin
      ce = 1'b1;
      cyc(n);
      ce = 1'b0;
      if (m_en) m_ticks += n;
    end
  endtask

  task automatic rise(input logic [NUM_CH-1:0] mask);
    cmp = mask;
    cyc(1);
    cmp = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (mask[ch] && m_armed[ch] && m_en) begin
        m_armed[ch] = 1'b0;
        if (m_fifo.size() < DEPTH) m_fifo.push_back((ch << 24) | m_ticks);
        else                       m_ovf = 1'b1;
      end
    end
    cyc(NUM_CH + 2);
  endtask

  task automatic chk_irq();
    check("irq", irq, (m_fifo.size() != 0) && m_irq_en);
  endtask

  task automatic drain();
    while (m_fifo.size() != 0) begin
      rd(4'd1);
      rd(4'd2);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_if.wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ack_unexpected: actual=1 required=0");
      end else begin
        mon_x = exp_q.pop_front();
        check($sformatf("rdata_adr%0d", mon_x.adr), bus_if.wbs_dat_o, mon_x.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.wb_valid_i = 1'b0;
    bus_if.wbs_adr_i  = '0;
    bus_if.wbs_dat_i  = '0;
    bus_if.wbs_strb_i = 1'b0;
    m_armed = '0; m_ticks = 0; m_ovf = 0; m_en = 0; m_irq_en = 0;
    cyc(3);
    check("reset_ack", bus_if.wbs_ack_o, 0);
    check("reset_dat", bus_if.wbs_dat_o, 0);
    check("reset_irq", irq, 0);
    rst_n = 1'b1;
    cyc(1);
    rd(4'd0); rd(4'd4); rd(4'd5); rd(4'd3);

    // single echo on ch2 after 100 ticks
    wr_ctrl(16'h0001);
    ping();
    ticks(100);
    rise(6'b000100);
    rd(4'd0); rd(4'd1); rd(4'd2); rd(4'd0);
    chk_irq();

    // simultaneous edges on 0, 3, 5 at timer 0x123
    ping();
    ticks(32'h123);
    rise(6'b101001);
    rd(4'd5); rd(4'd4);
    drain();

    // double toggle within a ping, then re-arm
    ping();
    ticks(7);
    rise(6'b000010);
    rise(6'b000010);
    rd(4'd0);
    ping();
    ticks(3);
    rise(6'b000010);
    rd(4'd0);
    drain();

    // two pings with no reads overflow the FIFO
    ping();
    rise('1);
    ping();
    ticks(5);
    rise('1);
    rd(4'd0);
    wr_ctrl(16'h0005);
    rd(4'd0);
    drain();
    rd(4'd0);

    // held valid gives one ack and one pop; empty read pops nothing
    ping();
    ticks(9);
    rise(6'b000001);
    bus_acc(1'b0, 4'd2, 16'h0, 4);
    rd(4'd0); rd(4'd2); rd(4'd0);

    // flush, unmapped addresses, irq
    ping();
    rise(6'b000111);
    wr_ctrl(16'h0009);
    rd(4'd0);
    rd(4'd9);
    bus_acc(1'b1, 4'd12, 16'hFFFF, 1);
    wr_ctrl(16'h0003);
    ping();
    rise(6'b000001);
    chk_irq();
    rd(4'd2);
    chk_irq();

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 6))
        0: ping();
        1: ticks($urandom_range(0, 20));
        2: rise(6'($urandom_range(1, 63)));
        3: rd(4'($urandom_range(0, 7)));
        4: begin rd(4'd1); rd(4'd2); end
        5: wr_ctrl({12'h0, 1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0)});
        default: wr_ctrl({12'h0, 1'($urandom_range(0, 7) == 0), 3'b011});
      endcase
      chk_irq();
    end

    // async reset while three entries are queued and an ack is outstanding
    wr_ctrl(16'h000B);
    ping();
    ticks(4);
    rise(6'b000111);
    rd(4'd0);
    chk_irq();
    bus_if.wb_valid_i = 1'b1;
    bus_if.wbs_adr_i  = 4'd1;
    bus_if.wbs_strb_i = 1'b0;
    @(posedge clk);
    #1;
    check("ack_before_reset", bus_if.wbs_ack_o, 1);
    rst_n = 1'b0;
    #1;
    check("async_ack", bus_if.wbs_ack_o, 0);
    check("async_dat", bus_if.wbs_dat_o, 0);
    check("async_irq", irq, 0);
    bus_if.wb_valid_i = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    m_fifo.delete(); m_armed = '0; m_ticks = 0; m_ovf = 0; m_en = 0; m_irq_en = 0;
    rd(4'd5); rd(4'd0); rd(4'd4); rd(4'd3);

    cyc(5);
    check("exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
